timer_ctrl: RTL
===============

# timer_ctrl

Sequencing controller for the cascaded `counter_10` decade chain in the countdown timer. It converts debounced button pulses and a prescaled 1 Hz tick into single-cycle INC/DEC/clear strobes for the chain. It reads back ZERO/MAX status from the chain and runs the IDLE/RUN/PAUSE/ALARM state machine that drives the alarm and status outputs.

## Interface
Parameters:
- TICK_DIV, 50000000: CLK cycles per count-down tick. Must be > PULSE_GAP+2.
- PULSE_GAP, 4: minimum CLK cycles with INC/DEC low after any strobe, so the ripple chain can settle.
- ALARM_LEN, 10: number of ticks ALARM stays asserted.

Ports:
- CLK  in  1  clock; all logic on posedge.
- CLR  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle pulse: start/pause toggle.
- UP  in  1  one-cycle pulse: add one to the setting.
- DOWN  in  1  one-cycle pulse: subtract one from the setting.
- CANCEL  in  1  one-cycle pulse: abort and clear.
- ZERO  in  1  chain reads all zeros.
- MAX  in  1  chain reads its maximum value.
- INC  out  1  one-cycle increment strobe to the chain.
- DEC  out  1  one-cycle decrement strobe to the chain.
- CNT_CLR  out  1  clear to the chain.
- ALARM  out  1  alarm active.
- RUNNING  out  1  high in RUN.
- STATE  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- BLANK  out  1  display blank, used for blinking.

## Operation
- Registered outputs only. INC and DEC are never high together.
- Gap counter: any INC/DEC strobe loads PULSE_GAP. While the gap counter is nonzero:
  - no new strobe is issued;
  - UP/DOWN pulses are dropped, not queued;
  - ZERO and MAX are not acted on.
- Prescaler: counts 0..TICK_DIV-1 and produces a one-cycle tick at wrap. It is forced to 0 on every entry to RUN and to ALARM.
- IDLE:
  - UP with MAX=0 → INC. UP with MAX=1 is ignored (no wrap).
  - DOWN with ZERO=0 → DEC. DOWN with ZERO=1 is ignored.
  - START with ZERO=0 and gap idle → RUN. START with ZERO=1 is ignored.
- RUN:
  - Each tick → DEC.
  - When the gap counter expires after a DEC and ZERO=1 → ALARM.
  - START → PAUSE. UP/DOWN are ignored.
- PAUSE: prescaler holds its value. START → RUN, which clears the prescaler. UP/DOWN are ignored.
- ALARM:
  - ALARM=1 for ALARM_LEN ticks, then → IDLE.
  - Any START/UP/DOWN pulse → IDLE immediately. That pulse is consumed and has no other effect.
- CANCEL in any state: CNT_CLR=1 for one cycle, → IDLE, gap counter loaded with PULSE_GAP.
- Priority within a cycle: CLR > CANCEL > START > UP/DOWN.
- UP and DOWN in the same cycle: both ignored.

## Timing
- Reset values: STATE=IDLE, INC=0, DEC=0, ALARM=0, RUNNING=0, BLANK=0, prescaler=0, gap=0.
- CNT_CLR is 1 while CLR is high and for the first cycle after CLR falls. It is 0 otherwise, except on CANCEL.
- Button-to-strobe latency: pulse at edge n → INC/DEC high for edge n+1 only.
- START in IDLE at edge n → STATE=RUN and RUNNING=1 after edge n+1. The first DEC is then TICK_DIV cycles later.
- A tick-driven DEC is issued in the cycle after the tick.
- RUN→ALARM is taken exactly PULSE_GAP+1 cycles after the final DEC.
- CLR asserted mid-operation: the next edge fully resets state. A strobe already issued completes (it is one cycle wide), and no further strobe follows.

## Configuration
- TIMER_BLINK_EN defined: BLANK toggles every TICK_DIV/2 cycles while in PAUSE or ALARM. It is 0 in IDLE and RUN, and 0 on entry to each state.
- TIMER_BLINK_EN undefined: BLANK is tied to 0 and no half-tick logic is generated.

## Test plan
- Reset, then UP×3 spaced 10 cycles apart with MAX=0 → exactly 3 INC strobes, each 1 cycle wide, each 1 cycle after its UP.
- UP pulses 2 cycles apart (PULSE_GAP=4) → only the first produces INC.
- DOWN with ZERO=1 → no DEC. UP with MAX=1 → no INC. UP+DOWN in the same cycle → no strobe.
- TICK_DIV=16, setting 2, START:
  - DEC at cycles 16 and 32 after RUN entry;
  - ZERO driven to 1 → STATE=ALARM 5 cycles after the second DEC;
  - ALARM high for 10 ticks, then IDLE.
- RUN, START → PAUSE with no DECs for 100 cycles; START → RUN, next DEC after TICK_DIV cycles. CANCEL in RUN → CNT_CLR 1 cycle, STATE=IDLE.
- With TIMER_BLINK_EN and TICK_DIV=16 in PAUSE → BLANK toggles every 8 cycles. CLR mid-RUN → all outputs at reset values next cycle, CNT_CLR high.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: button pulses, chain status and strobe/status outputs of timer_ctrl.
interface timer_ctrl_if;
    logic       START;
    logic       UP;
    logic       DOWN;
    logic       CANCEL;
    logic       ZERO;
    logic       MAX;
    logic       INC;
    logic       DEC;
    logic       CNT_CLR;
    logic       ALARM;
    logic       RUNNING;
    logic       BLANK;
    logic [1:0] STATE;
    modport master (
        output START, UP, DOWN, CANCEL, ZERO, MAX,
        input  INC, DEC, CNT_CLR, ALARM, RUNNING, BLANK, STATE
    );
    modport slave (
        input  START, UP, DOWN, CANCEL, ZERO, MAX,
        output INC, DEC, CNT_CLR, ALARM, RUNNING, BLANK, STATE
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: IDLE/RUN/PAUSE/ALARM sequencer issuing INC/DEC/clear strobes to the counter_10 chain.
// Define TIMER_BLINK_EN to blink BLANK every half tick in PAUSE and ALARM.
module timer_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int PULSE_GAP = 4,
    parameter int ALARM_LEN = 10
) (
    input logic CLK,
    input logic CLR,
    timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_ALARM = 2'd3} state_t;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(PULSE_GAP + 1);
    localparam int AW = $clog2(ALARM_LEN + 1);
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] ticks_q, ticks_d;
    logic          inc_q, inc_d, dec_q, dec_d, clr_q, clr_d;
    logic          alarm_q, alarm_d, run_q, run_d;
    logic          tick, gap_idle, up_only, dn_only;
    always_comb begin
        tick = presc_q == PW'(TICK_DIV - 1);
        gap_idle = gap_q == '0;
        up_only = bus.UP && !bus.DOWN;
        dn_only = bus.DOWN && !bus.UP;
        state_d = state_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        clr_d = 1'b0;
        if (bus.CANCEL) begin
            state_d = S_IDLE;
            clr_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // START owns the cycle even when it is ignored
                    if (bus.START) begin
                        if (!bus.ZERO && gap_idle) state_d = S_RUN;
                    end else if (gap_idle) begin
                        inc_d = up_only && !bus.MAX;
                        dec_d = dn_only && !bus.ZERO;
                    end
                end
                S_RUN: begin
                    if (bus.START) state_d = S_PAUSE;
                    else if (gap_idle && bus.ZERO) state_d = S_ALARM;
                    else dec_d = tick && gap_idle;
                end
                S_PAUSE: begin
                    if (bus.START) state_d = S_RUN;
                end
                default: begin
                    if (bus.START || bus.UP || bus.DOWN || (tick && ticks_q == AW'(ALARM_LEN - 1)))
                        state_d = S_IDLE;
                end
            endcase
        end
        gap_d = (inc_d || dec_d || clr_d) ? GW'(PULSE_GAP) : gap_idle ? gap_q : gap_q - 1'b1;
        presc_d = (state_d != state_q || state_d == S_IDLE) ? '0 :
                  (state_d == S_PAUSE) ? presc_q : tick ? '0 : presc_q + 1'b1;
        ticks_d = (state_d != state_q) ? '0 : (state_q == S_ALARM && tick) ? ticks_q + 1'b1 : ticks_q;
        alarm_d = state_d == S_ALARM;
        run_d = state_d == S_RUN;
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            gap_q <= '0;
            ticks_q <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            clr_q <= 1'b1;
            alarm_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            gap_q <= gap_d;
            ticks_q <= ticks_d;
            inc_q <= inc_d;
            dec_q <= dec_d;
            clr_q <= clr_d;
            alarm_q <= alarm_d;
            run_q <= run_d;
        end
    end
    assign bus.INC = inc_q;
    assign bus.DEC = dec_q;
    assign bus.CNT_CLR = clr_q;
    assign bus.ALARM = alarm_q;
    assign bus.RUNNING = run_q;
    assign bus.STATE = state_q;
`ifdef TIMER_BLINK_EN
    localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    logic [HW-1:0] half_q, half_d;
    logic          blank_q, blank_d;
    logic          half_wrap;
    // half-tick phase restarts on every state change so BLANK always enters low
    always_comb begin
        half_wrap = half_q == HW'(HALF - 1);
        half_d = '0;
        blank_d = 1'b0;
        if (state_d == state_q && (state_q == S_PAUSE || state_q == S_ALARM)) begin
            half_d = half_wrap ? '0 : half_q + 1'b1;
            blank_d = half_wrap ? !blank_q : blank_q;
        end
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            half_q <= '0;
            blank_q <= 1'b0;
        end else begin
            half_q <= half_d;
            blank_q <= blank_d;
        end
    end
    assign bus.BLANK = blank_q;
`else
    assign bus.BLANK = 1'b0;
`endif
endmodule
